// File: rtl/mem_pkg.sv
// Shared widths, FSM state type and address range helper for the data-memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_RESP
  } mem_state_t;

  // True when addr maps onto one of the depth words starting at base.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] depth);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 3) < depth);
  endfunction

endpackage

// File: rtl/mem_sram_bytemask.sv
// Doubleword SRAM with byte enables: combinational read, synchronous write, and
// forwarding of the same-cycle write so a concurrent read sees merged bytes.
module mem_sram_bytemask
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Byte-masked write commit; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Array read with write-before-read merge on a same-word collision.
  always_comb begin
    rdata_o = mem_q[ridx_i];
    if (we_i && (widx_i == ridx_i)) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask_i[b]) rdata_o[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_slave.sv
// Data-memory responder: accepts one read and/or write request at a time, serves it
// from the byte-maskable SRAM, and signals busy until the response has been given.
module mem_slave
  import mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned       RD_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ren_i,
  input  logic [ADDR_W-1:0] mem_raddr_i,
  input  logic              mem_wen_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [MASK_W-1:0] mem_wmask_i,
  input  logic              rwvalid_i,
  input  logic              flush_flag_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              rdata_valid_o,
  output logic              wr_done_o,
  output logic              busy_o,
  output logic              addr_err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  // RD_WAIT counts down to zero, so it is loaded with two less than the latency.
  localparam logic [2:0]  CntInit = (RD_LATENCY >= 2) ? 3'(RD_LATENCY - 2) : 3'd0;

  mem_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              err_q, err_d;

  logic              accept, rd_acc, wr_acc;
  logic              rd_ok, wr_ok;
  logic [IdxW-1:0]   ridx, widx;
  logic [DATA_W-1:0] sram_rdata;

  // Request decode and word indexing.
  always_comb begin
    accept = (state_q == IDLE) && rwvalid_i && !flush_flag_i && (mem_ren_i || mem_wen_i);
    rd_acc = accept && mem_ren_i;
    wr_acc = accept && mem_wen_i;
    rd_ok  = in_range(mem_raddr_i, BASE_ADDR, ADDR_W'(DEPTH_WORDS));
    wr_ok  = in_range(mem_waddr_i, BASE_ADDR, ADDR_W'(DEPTH_WORDS));
    ridx   = IdxW'((mem_raddr_i - BASE_ADDR) >> 3);
    widx   = IdxW'((mem_waddr_i - BASE_ADDR) >> 3);
  end

  mem_sram_bytemask #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxW)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (wr_acc && wr_ok),
    .widx_i  (widx),
    .wdata_i (mem_wdata_i),
    .wmask_i (mem_wmask_i),
    .ridx_i  (ridx),
    .rdata_o (sram_rdata)
  );

  // Response strobes; a flush kills a read response in the same cycle.
  always_comb begin
    rdata_valid_o = (state_q == RD_RESP) && !flush_flag_i;
    wr_done_o     = (state_q == WR_RESP);
    busy_o        = (state_q != IDLE);
    addr_err_o    = err_q && (rdata_valid_o || wr_done_o);
    mem_rdata_o   = rdata_valid_o ? cap_q : out_q;
  end

  // Next-state, latency counter and response data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    out_d   = out_q;
    err_d   = err_q;

    if (accept) begin
      err_d = (mem_ren_i && !rd_ok) || (mem_wen_i && !wr_ok);
    end
    if (rd_acc) begin
      cap_d = rd_ok ? sram_rdata : '0;
    end
    if (rdata_valid_o) begin
      out_d = cap_q;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          if (RD_LATENCY == 1) begin
            state_d = RD_RESP;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CntInit;
          end
        end else if (wr_acc) begin
          state_d = WR_RESP;
        end
      end
      RD_WAIT: begin
        if (flush_flag_i) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_RESP: state_d = IDLE;
      WR_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      cap_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_slave.sv
// Directed bench for mem_slave: one instance at latency 2 for the main paths and
// one at latency 4 for the flush scenario, sharing request lines.
module tb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren, wen, rv, flush, use_b;
  logic [63:0] raddr, waddr, wdata;
  logic [7:0]  wmask;

  logic [63:0] a_rdata, b_rdata, o_rdata;
  logic        a_valid, a_done, a_busy, a_err;
  logic        b_valid, b_done, b_busy, b_err;
  logic        o_valid, o_done, o_busy, o_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_slave #(
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (64'h8000_0000),
    .RD_LATENCY  (2)
  ) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .mem_ren_i     (ren),
    .mem_raddr_i   (raddr),
    .mem_wen_i     (wen),
    .mem_waddr_i   (waddr),
    .mem_wdata_i   (wdata),
    .mem_wmask_i   (wmask),
    .rwvalid_i     (rv && !use_b),
    .flush_flag_i  (flush),
    .mem_rdata_o   (a_rdata),
    .rdata_valid_o (a_valid),
    .wr_done_o     (a_done),
    .busy_o        (a_busy),
    .addr_err_o    (a_err)
  );

  mem_slave #(
    .DEPTH_WORDS (16),
    .BASE_ADDR   (64'h8000_0000),
    .RD_LATENCY  (4)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .mem_ren_i     (ren),
    .mem_raddr_i   (raddr),
    .mem_wen_i     (wen),
    .mem_waddr_i   (waddr),
    .mem_wdata_i   (wdata),
    .mem_wmask_i   (wmask),
    .rwvalid_i     (rv && use_b),
    .flush_flag_i  (flush),
    .mem_rdata_o   (b_rdata),
    .rdata_valid_o (b_valid),
    .wr_done_o     (b_done),
    .busy_o        (b_busy),
    .addr_err_o    (b_err)
  );

  assign o_rdata = use_b ? b_rdata : a_rdata;
  assign o_valid = use_b ? b_valid : a_valid;
  assign o_done  = use_b ? b_done  : a_done;
  assign o_busy  = use_b ? b_busy  : a_busy;
  assign o_err   = use_b ? b_err   : a_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ren   = 1'b0;
    wen   = 1'b0;
    rv    = 1'b0;
    flush = 1'b0;
  endtask

  // Write presented in the current cycle; checks the T+1 completion and T+2 idle.
  task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] mask, input logic exp_err);
    wen = 1'b1; waddr = addr; wdata = data; wmask = mask; rv = 1'b1;
    tick(); idle_inputs(); #3;
    chk("wr_done", o_done, 1);
    chk("wr_busy", o_busy, 1);
    chk("wr_err", o_err, exp_err);
    tick(); #3;
    chk("wr_done_off", o_done, 0);
    chk("wr_busy_off", o_busy, 0);
  endtask

  // Read presented in the current cycle; response expected exactly lat cycles later.
  task automatic do_read(input logic [63:0] addr, input logic [63:0] exp,
                         input logic exp_err, input int lat);
    ren = 1'b1; raddr = addr; rv = 1'b1;
    for (int i = 1; i < lat; i++) begin
      tick(); idle_inputs(); #3;
      chk("rd_wait_busy", o_busy, 1);
      chk("rd_wait_valid", o_valid, 0);
    end
    tick(); idle_inputs(); #3;
    chk("rd_valid", o_valid, 1);
    chk("rd_data", o_rdata, exp);
    chk("rd_err", o_err, exp_err);
    tick(); #3;
    chk("rd_valid_off", o_valid, 0);
    chk("rd_busy_off", o_busy, 0);
    chk("rd_data_hold", o_rdata, exp);
  endtask

  initial begin
    idle_inputs();
    use_b = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; wmask = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #4;
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rdata, 64'h0);
    chk("rst_b_rdata", b_rdata, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Basic write/read
    do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);
    do_read(64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 2);

    // Partial mask over all-ones word
    do_write(64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    do_write(64'h8000_0018, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0);
    do_read(64'h8000_0018, 64'hFFFF_FFFF_AAAA_AAAA, 1'b0, 2);

    // Simultaneous read and write to the same zeroed word
    do_write(64'h8000_0020, 64'h0, 8'hFF, 1'b0);
    ren = 1'b1; raddr = 64'h8000_0020;
    wen = 1'b1; waddr = 64'h8000_0020; wdata = 64'h5; wmask = 8'h01; rv = 1'b1;
    tick(); idle_inputs(); #3;
    chk("rw_done_t1", o_done, 0);
    chk("rw_busy_t1", o_busy, 1);
    tick(); #3;
    chk("rw_valid", o_valid, 1);
    chk("rw_data", o_rdata, 64'h5);
    chk("rw_done_t2", o_done, 0);
    tick(); #3;
    do_read(64'h8000_0020, 64'h5, 1'b0, 2);

    // Out of range: low read, high write aliasing word 0 must not land
    do_write(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    do_read(64'h7FFF_FFF8, 64'h0, 1'b1, 2);
    do_write(64'h8000_8000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b1);
    do_read(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 1'b0, 2);

    // Write presented while busy is dropped
    ren = 1'b1; raddr = 64'h8000_0010; rv = 1'b1;
    tick(); idle_inputs();
    wen = 1'b1; waddr = 64'h8000_0010; wdata = 64'hDEAD_BEEF_DEAD_BEEF; wmask = 8'hFF;
    rv = 1'b1;
    #3;
    chk("drop_busy", o_busy, 1);
    tick(); idle_inputs(); #3;
    chk("drop_valid", o_valid, 1);
    chk("drop_rdata", o_rdata, 64'h1122_3344_5566_7788);
    chk("drop_done_t2", o_done, 0);
    tick(); #3;
    chk("drop_done_t3", o_done, 0);
    chk("drop_busy_off", o_busy, 0);
    do_read(64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 2);

    // Asynchronous reset in RD_WAIT
    ren = 1'b1; raddr = 64'h8000_0018; rv = 1'b1;
    tick(); idle_inputs(); #2;
    chk("pre_rst_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_rdata", o_rdata, 64'h0);
    chk("arst_err", o_err, 0);
    tick(); tick();
    rst = 1'b0;
    #3;
    do_read(64'h8000_0018, 64'hFFFF_FFFF_AAAA_AAAA, 1'b0, 2);

    // Flush during a latency-4 read
    use_b = 1'b1;
    do_write(64'h8000_0000, 64'hCAFE_F00D_0000_0001, 8'hFF, 1'b0);
    do_read(64'h8000_0000, 64'hCAFE_F00D_0000_0001, 1'b0, 4);
    do_write(64'h8000_0008, 64'h0BAD_BEEF_0000_0002, 8'hFF, 1'b0);
    ren = 1'b1; raddr = 64'h8000_0008; rv = 1'b1;
    tick(); idle_inputs(); #3;
    chk("fl_busy_t1", o_busy, 1);
    tick();
    flush = 1'b1;
    #3;
    chk("fl_valid_t2", o_valid, 0);
    chk("fl_rdata_t2", o_rdata, 64'hCAFE_F00D_0000_0001);
    tick(); idle_inputs(); #3;
    chk("fl_busy_t3", o_busy, 0);
    chk("fl_valid_t3", o_valid, 0);
    chk("fl_rdata_t3", o_rdata, 64'hCAFE_F00D_0000_0001);
    do_read(64'h8000_0008, 64'h0BAD_BEEF_0000_0002, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
